// File: rtl/prng_stream.sv
// rtl/prng_stream.sv - parametrised LFSR random word source with valid/ready output
//
// Purpose: Fibonacci-style LFSR that collects one feedback bit per step into
// an OUT_W-bit word, presents the word on a registered valid/ready stream and
// stalls while the word is pending. Supports run-time reseeding with all-zero
// lock-up protection and a raw or whitened word mode.
//
// Ports:
//   clk        clock, all registers update on the rising edge
//   rst        synchronous active-high reset
//   en         generation enable, freezes the LFSR and bit counter when low
//   mode       0 = raw word, 1 = word XOR top OUT_W bits of the LFSR
//   seed_load  single-cycle strobe that loads seed_data
//   seed_data  new seed value (zero is replaced by SEED_DEFAULT)
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts the word
//   out_data   random word
//   state_out  current LFSR state
module prng_stream #(
  parameter int                 STATE_W      = 16,
  parameter int                 OUT_W        = 8,
  parameter logic [STATE_W-1:0] TAPS         = 16'hD008,
  parameter logic [STATE_W-1:0] SEED_DEFAULT = 16'h0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               seed_load,
  input  logic [STATE_W-1:0] seed_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [STATE_W-1:0] state_out
);

  localparam int CNT_W = (OUT_W > 2) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [STATE_W-1:0] lfsr, lfsr_next;
  logic [OUT_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [OUT_W-1:0]   data_next;
  logic               valid_next;

  logic               fb;
  logic [STATE_W-1:0] lfsr_step;
  logic [OUT_W-1:0]   acc_step;

  // The first collected bit of a word is shifted furthest and lands at the MSB.
  assign fb        = ^(lfsr & TAPS);
  assign lfsr_step = {lfsr[STATE_W-2:0], fb};
  assign acc_step  = {acc[OUT_W-2:0], fb};
  assign state_out = lfsr;

  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    acc_next   = acc;
    cnt_next   = cnt;
    data_next  = out_data;
    valid_next = out_valid;

    if (seed_load) begin
      // A zero seed would lock the LFSR, so it is replaced by the default.
      lfsr_next  = (seed_data == '0) ? SEED_DEFAULT : seed_data;
      acc_next   = '0;
      cnt_next   = '0;
      valid_next = 1'b0;
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          if (en) begin
            lfsr_next = lfsr_step;
            acc_next  = acc_step;
            if (cnt == CNT_LAST) begin
              cnt_next   = '0;
              // Whitening uses the LFSR as it stands after the completing step.
              data_next  = mode ? (acc_step ^ lfsr_step[STATE_W-1 -: OUT_W]) : acc_step;
              valid_next = 1'b1;
              state_next = HOLD;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            valid_next = 1'b0;
            state_next = FILL;
          end
        end
        default: begin
          state_next = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      lfsr      <= SEED_DEFAULT;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      lfsr      <= lfsr_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      out_data  <= data_next;
      out_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_prng_stream.sv
// tb/tb_prng_stream.sv - self-checking bench for prng_stream (16/8 default and 4/4 instances)
module tb_prng_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        en [2];
  logic        mode [2];
  logic        seed_load [2];
  logic        out_ready [2];
  logic        out_valid [2];
  logic [15:0] sd0, so0;
  logic [7:0]  od0;
  logic [3:0]  sd1, so1, od1;

  int tests = 0;
  int fails = 0;
  bit chk = 1'b0;

  always #5 clk = ~clk;

  prng_stream dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .mode(mode[0]),
    .seed_load(seed_load[0]), .seed_data(sd0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od0), .state_out(so0)
  );

  prng_stream #(.STATE_W(4), .OUT_W(4), .TAPS(4'hC), .SEED_DEFAULT(4'h1)) dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .mode(mode[1]),
    .seed_load(seed_load[1]), .seed_data(sd1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od1), .state_out(so1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer LFSR plus a bit collector that counts bits
  // toward a word and a pending-word flag.
  int p_sw [2]   = '{16, 4};
  int p_ow [2]   = '{8, 4};
  int p_taps [2] = '{'hD008, 'hC};
  int p_sdef [2] = '{1, 1};
  int m_lfsr [2];
  int m_acc [2];
  int m_nb [2];
  int m_data [2];
  int m_valid [2];

  function automatic int parity(input int v);
    int p = 0;
    for (int i = 0; i < 32; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  task automatic model_step(input int k, input int seed);
    int smask = (1 << p_sw[k]) - 1;
    int omask = (1 << p_ow[k]) - 1;
    int b;
    if (rst) begin
      m_lfsr[k] = p_sdef[k]; m_acc[k] = 0; m_nb[k] = 0; m_data[k] = 0; m_valid[k] = 0;
    end else if (seed_load[k]) begin
      m_lfsr[k]  = ((seed & smask) != 0) ? (seed & smask) : p_sdef[k];
      m_acc[k]   = 0;
      m_nb[k]    = 0;
      m_valid[k] = 0;
    end else if (m_valid[k] != 0) begin
      if (out_ready[k]) m_valid[k] = 0;
    end else if (en[k]) begin
      b = parity(m_lfsr[k] & p_taps[k]);
      m_lfsr[k] = ((m_lfsr[k] * 2) + b) & smask;
      m_acc[k]  = ((m_acc[k] * 2) + b) & omask;
      m_nb[k]++;
      if (m_nb[k] == p_ow[k]) begin
        m_data[k]  = mode[k] ? (m_acc[k] ^ (m_lfsr[k] >> (p_sw[k] - p_ow[k]))) : m_acc[k];
        m_valid[k] = 1;
        m_nb[k]    = 0;
        m_acc[k]   = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, int'(sd0));
    model_step(1, int'(sd1));
  end

  always @(negedge clk) begin
    if (chk) begin
      check("model_valid0", 32'(out_valid[0]), 32'(m_valid[0]));
      check("model_data0",  32'(od0),          32'(m_data[0]));
      check("model_state0", 32'(so0),          32'(m_lfsr[0]));
      check("model_valid1", 32'(out_valid[1]), 32'(m_valid[1]));
      check("model_data1",  32'(od1),          32'(m_data[1]));
      check("model_state1", 32'(so1),          32'(m_lfsr[1]));
    end
  end

  task automatic idle_all;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; mode[k] = 1'b0; seed_load[k] = 1'b0; out_ready[k] = 1'b0;
    end
    sd0 = '0;
    sd1 = '0;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for out_valid on instance k; n returns the edges waited.
  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (n < 50 && out_valid[k] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    if (out_valid[k] !== 1'b1) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int first_v;
    int seq[$];
    int words[$];
    int exp_seq[16] = '{1, 2, 4, 9, 3, 6, 'hD, 'hA, 5, 'hB, 7, 'hF, 'hE, 'hC, 8, 1};
    int exp_words[3] = '{3, 5, 'hE};
    bit any_zero;
    logic [3:0] hold_d, hold_s;

    idle_all();
    rst = 1'b1;
    @(negedge clk);
    chk = 1'b1;
    @(negedge clk);
    check("rst_valid0", 32'(out_valid[0]), 32'd0);
    check("rst_data0",  32'(od0),          32'd0);
    check("rst_state0", 32'(so0),          32'h0001);
    check("rst_state1", 32'(so1),          32'h1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("en_low_state0", 32'(so0), 32'h0001);

    // Period and raw words on the 4/4 instance.
    reset_dut();
    en[1] = 1'b1; out_ready[1] = 1'b1; mode[1] = 1'b0;
    seq.push_back(int'(so1));
    first_v = 0;
    any_zero = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (so1 == 4'h0) any_zero = 1'b1;
      if (int'(so1) != seq[$]) seq.push_back(int'(so1));
      if (out_valid[1] === 1'b1) begin
        if (first_v == 0) first_v = c;
        words.push_back(int'(od1));
      end
    end
    check("first_valid_edge", 32'(first_v), 32'd4);
    check("no_zero_state", 32'(any_zero), 32'd0);
    check("seq_len", 32'(seq.size() >= 16), 32'd1);
    if (seq.size() >= 16)
      for (int i = 0; i < 16; i++) check($sformatf("period_state[%0d]", i), 32'(seq[i]), 32'(exp_seq[i]));
    check("word_count", 32'(words.size() >= 3), 32'd1);
    if (words.size() >= 3)
      for (int i = 0; i < 3; i++) check($sformatf("raw_word[%0d]", i), 32'(words[i]), 32'(exp_words[i]));

    // Whitened first word on 4/4: acc 0011 XOR post-step lfsr 0011.
    idle_all();
    reset_dut();
    en[1] = 1'b1; out_ready[1] = 1'b1; mode[1] = 1'b1;
    wait_valid(1, n);
    check("white_word_4", 32'(od1), 32'h0);

    // Zero seed in the middle of a word.
    idle_all();
    reset_dut();
    en[1] = 1'b1; out_ready[1] = 1'b1;
    repeat (2) @(negedge clk);
    seed_load[1] = 1'b1; sd1 = 4'h0;
    @(negedge clk);
    seed_load[1] = 1'b0;
    check("zero_seed_state", 32'(so1), 32'h1);
    check("zero_seed_valid", 32'(out_valid[1]), 32'd0);
    wait_valid(1, n);
    check("zero_seed_edges", 32'(n), 32'd4);
    check("zero_seed_word", 32'(od1), 32'h3);

    // Backpressure with en toggling.
    idle_all();
    reset_dut();
    en[1] = 1'b1; out_ready[1] = 1'b0;
    wait_valid(1, n);
    hold_d = od1;
    hold_s = so1;
    for (int i = 0; i < 10; i++) begin
      en[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_valid", 32'(out_valid[1]), 32'd1);
      check("bp_data",  32'(od1), 32'(hold_d));
      check("bp_state", 32'(so1), 32'(hold_s));
    end
    out_ready[1] = 1'b1;
    en[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("bp_release_valid", 32'(out_valid[1]), 32'd0);
    wait_valid(1, n);
    check("bp_next_edges", 32'(n), 32'd4);

    // Default 16/8 instance: raw and whitened first words.
    idle_all();
    reset_dut();
    en[0] = 1'b1; out_ready[0] = 1'b1;
    wait_valid(0, n);
    check("raw_word_16", 32'(od0), 32'h11);
    check("raw_edges_16", 32'(n), 32'd8);
    idle_all();
    reset_dut();
    en[0] = 1'b1; out_ready[0] = 1'b1; mode[0] = 1'b1;
    wait_valid(0, n);
    check("white_word_16", 32'(od0), 32'h10);

    // Mixed stimulus on both instances, checked every cycle by the model.
    idle_all();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        en[k]        = ($urandom_range(0, 3) != 0);
        mode[k]      = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 2) != 0);
        seed_load[k] = ($urandom_range(0, 29) == 0);
      end
      sd0 = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      sd1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
